// File: rtl/myo_spi_responder.sv
// Motor-board responder for the 12-word myo SPI frame: serves snapshot status words
// to a word-level SPI slave core and publishes the PWM reference after a well-formed frame.
module myo_spi_responder #(
  parameter int          FRAME_WORDS  = 12,
  parameter logic [15:0] START_MARKER = 16'h8000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ss_n,
  input  logic        di_req,
  input  logic        write_ack,
  input  logic        do_valid,
  input  logic [15:0] do_word,
  input  logic [31:0] position,
  input  logic [15:0] velocity,
  input  logic [15:0] current,
  input  logic [15:0] displacement,
  input  logic [15:0] sensor1,
  input  logic [15:0] sensor2,
  output logic [15:0] tx_word,
  output logic        wren,
  output logic [15:0] pwm_ref,
  output logic        pwm_valid,
  output logic        frame_done,
  output logic        frame_error,
  output logic [15:0] frame_count,
  output logic [7:0]  error_count,
  output logic [1:0]  dbg_state
);

  localparam int TXW = $clog2(FRAME_WORDS + 1);
  localparam int RXW = $clog2(FRAME_WORDS + 2);
  localparam logic [TXW-1:0] TX_END  = TXW'(FRAME_WORDS);
  localparam logic [RXW-1:0] RX_FULL = RXW'(FRAME_WORDS);
  localparam logic [RXW-1:0] RX_MAX  = RXW'(FRAME_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REQ = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_ss_prev, r_di_prev, r_ack_prev, r_do_prev;
  logic [TXW-1:0]  r_tx_idx;
  logic [RXW-1:0]  r_rx_cnt;
  logic            r_marker_ok;
  logic [15:0]     r_pwm_shadow;
  logic [31:0]     r_pos_s;
  logic [15:0]     r_vel_s, r_cur_s, r_disp_s, r_s1_s, r_s2_s;
  logic [15:0]     r_tx_word, r_pwm_ref, r_frame_count;
  logic [7:0]      r_error_count;
  logic            r_wren, r_pwm_valid, r_frame_done, r_frame_error;

  logic            w_ss_fall, w_ss_rise, w_di_rise, w_ack_rise, w_do_rise, w_rx_event;
  logic [RXW-1:0]  w_rx_cnt_next;
  logic            w_marker_next, w_good;
  logic [15:0]     w_pwm_next, w_slot;

  // Handshake: a word on tx_word is offered while wren is high and is taken on the
  // rising edge of write_ack; di_req and do_valid likewise act only on their rising edges.
  assign w_ss_fall  = r_ss_prev & ~ss_n;
  assign w_ss_rise  = ~r_ss_prev & ss_n;
  assign w_di_rise  = ~r_di_prev & di_req;
  assign w_ack_rise = ~r_ack_prev & write_ack;
  assign w_do_rise  = ~r_do_prev & do_valid;
  assign w_rx_event = w_do_rise && (r_state != IDLE);

  // Receive bookkeeping is computed ahead so a word arriving with ss_n rise still counts.
  always_comb begin
    w_rx_cnt_next = r_rx_cnt;
    w_marker_next = r_marker_ok;
    w_pwm_next    = r_pwm_shadow;
    if (w_rx_event) begin
      if (r_rx_cnt != RX_MAX) w_rx_cnt_next = r_rx_cnt + 1'b1;
      if (r_rx_cnt == '0) w_marker_next = (do_word == START_MARKER);
      if (r_rx_cnt == RXW'(1)) w_pwm_next = do_word;
    end
    w_good = (w_rx_cnt_next == RX_FULL) && w_marker_next;
  end

  always_comb begin
    w_slot = 16'h0000;
    case (r_tx_idx)
      TXW'(5):  w_slot = r_pos_s[31:16];
      TXW'(6):  w_slot = r_pos_s[15:0];
      TXW'(7):  w_slot = r_vel_s;
      TXW'(8):  w_slot = r_cur_s;
      TXW'(9):  w_slot = r_disp_s;
      TXW'(10): w_slot = r_s1_s;
      TXW'(11): w_slot = r_s2_s;
      default:  w_slot = 16'h0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ss_prev     <= 1'b0;
      r_di_prev     <= 1'b0;
      r_ack_prev    <= 1'b0;
      r_do_prev     <= 1'b0;
      r_tx_idx      <= '0;
      r_rx_cnt      <= '0;
      r_marker_ok   <= 1'b0;
      r_pwm_shadow  <= 16'h0000;
      r_pos_s       <= 32'h0;
      r_vel_s       <= 16'h0;
      r_cur_s       <= 16'h0;
      r_disp_s      <= 16'h0;
      r_s1_s        <= 16'h0;
      r_s2_s        <= 16'h0;
      r_tx_word     <= 16'h0;
      r_wren        <= 1'b0;
      r_pwm_ref     <= 16'h0;
      r_pwm_valid   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
      r_frame_count <= 16'h0;
      r_error_count <= 8'h0;
    end else begin
      r_ss_prev     <= ss_n;
      r_di_prev     <= di_req;
      r_ack_prev    <= write_ack;
      r_do_prev     <= do_valid;
      r_pwm_valid   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
      if (r_state == IDLE) begin
        if (w_ss_fall) begin
          r_pos_s     <= position;
          r_vel_s     <= velocity;
          r_cur_s     <= current;
          r_disp_s    <= displacement;
          r_s1_s      <= sensor1;
          r_s2_s      <= sensor2;
          r_tx_idx    <= '0;
          r_rx_cnt    <= '0;
          r_marker_ok <= 1'b0;
          r_tx_word   <= 16'h0000;
          r_wren      <= 1'b1;
          r_state     <= WAIT_ACK;
        end
      end else begin
        r_rx_cnt     <= w_rx_cnt_next;
        r_marker_ok  <= w_marker_next;
        r_pwm_shadow <= w_pwm_next;
        if (w_ss_rise) begin
          r_wren  <= 1'b0;
          r_state <= IDLE;
          if (w_good) begin
            r_pwm_ref     <= {w_pwm_next[14], w_pwm_next[14:0]};
            r_pwm_valid   <= 1'b1;
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end else begin
            r_frame_error <= 1'b1;
            if (r_error_count != 8'hFF) r_error_count <= r_error_count + 8'd1;
          end
        end else if (r_state == WAIT_ACK && w_ack_rise) begin
          r_wren   <= 1'b0;
          r_tx_idx <= r_tx_idx + 1'b1;
          r_state  <= WAIT_REQ;
        end else if (r_state == WAIT_REQ && w_di_rise && r_tx_idx < TX_END) begin
          r_tx_word <= w_slot;
          r_wren    <= 1'b1;
          r_state   <= WAIT_ACK;
        end
      end
    end
  end

  assign tx_word     = r_tx_word;
  assign wren        = r_wren;
  assign pwm_ref     = r_pwm_ref;
  assign pwm_valid   = r_pwm_valid;
  assign frame_done  = r_frame_done;
  assign frame_error = r_frame_error;
  assign frame_count = r_frame_count;
  assign error_count = r_error_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_myo_spi_responder.sv
// Directed bench for myo_spi_responder: plays the SPI slave core, checks transmit
// slots through an expected queue and frame-end results against hand-computed values.
module tb_myo_spi_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        ss_n, di_req, write_ack, do_valid;
  logic [15:0] do_word;
  logic [31:0] position;
  logic [15:0] velocity, current, displacement, sensor1, sensor2;
  logic [15:0] tx_word, pwm_ref, frame_count;
  logic        wren, pwm_valid, frame_done, frame_error;
  logic [7:0]  error_count;
  logic [1:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_fc;
  logic [7:0]  exp_ec;

  myo_spi_responder dut (
    .clock(clock), .reset(reset), .ss_n(ss_n), .di_req(di_req),
    .write_ack(write_ack), .do_valid(do_valid), .do_word(do_word),
    .position(position), .velocity(velocity), .current(current),
    .displacement(displacement), .sensor1(sensor1), .sensor2(sensor2),
    .tx_word(tx_word), .wren(wren), .pwm_ref(pwm_ref), .pwm_valid(pwm_valid),
    .frame_done(frame_done), .frame_error(frame_error),
    .frame_count(frame_count), .error_count(error_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_slots();
    for (int s = 0; s < 5; s++) exp_q.push_back(16'h0000);
    exp_q.push_back(position[31:16]);
    exp_q.push_back(position[15:0]);
    exp_q.push_back(velocity);
    exp_q.push_back(current);
    exp_q.push_back(displacement);
    exp_q.push_back(sensor1);
    exp_q.push_back(sensor2);
  endtask

  // driver: one frame of n words as seen from the slave core
  task automatic run_frame(input int n, input logic [15:0] w0, input logic [15:0] w1,
                           input logic chg_pos, input logic good, input logic [15:0] exp_pwm);
    logic [15:0] e;
    exp_q.delete();
    push_slots();
    ss_n = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      if (i < 12) begin
        e = exp_q.pop_front();
        check($sformatf("wren_on_%0d", i), {31'b0, wren}, 32'd1);
        check($sformatf("tx_slot_%0d", i), {16'b0, tx_word}, {16'b0, e});
        write_ack = 1'b1;
        step();
        write_ack = 1'b0;
        check($sformatf("wren_off_%0d", i), {31'b0, wren}, 32'd0);
      end
      if (i == 0 && chg_pos) position = 32'h0003_0004;
      do_word  = (i == 0) ? w0 : (i == 1) ? w1 : 16'h0000;
      do_valid = 1'b1;
      step();
      do_valid = 1'b0;
      if (i < n - 1) begin
        di_req = 1'b1;
        step();
        di_req = 1'b0;
      end
    end
    ss_n = 1'b1;
    step();
    if (good) exp_fc = exp_fc + 16'd1;
    else if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
    check("frame_done",  {31'b0, frame_done},  {31'b0, good});
    check("pwm_valid",   {31'b0, pwm_valid},   {31'b0, good});
    check("frame_error", {31'b0, frame_error}, {31'b0, ~good});
    check("pwm_ref",     {16'b0, pwm_ref},     {16'b0, exp_pwm});
    check("frame_count", {16'b0, frame_count}, {16'b0, exp_fc});
    check("error_count", {24'b0, error_count}, {24'b0, exp_ec});
    check("wren_end",    {31'b0, wren},        32'd0);
    step();
    check("pulse_len",   {29'b0, frame_done, pwm_valid, frame_error}, 32'd0);
  endtask

  task automatic quick_bad_frame();
    ss_n = 1'b0;
    step();
    ss_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; ss_n = 1'b1; di_req = 1'b0; write_ack = 1'b0; do_valid = 1'b0;
    do_word = 16'h0; position = 32'h0001_0002; velocity = 16'd3; current = 16'd4;
    displacement = 16'd5; sensor1 = 16'd6; sensor2 = 16'd7;
    exp_fc = 16'd0; exp_ec = 8'd0;
    repeat (3) step();
    check("rst_wren",   {31'b0, wren}, 32'd0);
    check("rst_tx",     {16'b0, tx_word}, 32'd0);
    check("rst_pwm",    {16'b0, pwm_ref}, 32'd0);
    check("rst_pulses", {29'b0, frame_done, pwm_valid, frame_error}, 32'd0);
    check("rst_counts", {8'b0, frame_count, error_count}, 32'd0);
    check("rst_state",  {30'b0, dbg_state}, 32'd0);
    reset = 1'b0;
    step();
    step();

    // good frame and sign extension of word 1 bits [14:0]
    run_frame(12, 16'h8000, 16'h1234, 1'b0, 1'b1, 16'h1234);
    run_frame(12, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'hFFFF);
    run_frame(12, 16'h8000, 16'h4000, 1'b0, 1'b1, 16'hC000);

    // snapshot: position changes mid-frame, next frame sees the new value
    run_frame(12, 16'h8000, 16'h0100, 1'b1, 1'b1, 16'h0100);
    run_frame(12, 16'h8000, 16'h0200, 1'b0, 1'b1, 16'h0200);

    // short frame, then recovery
    run_frame(7,  16'h8000, 16'h5555, 1'b0, 1'b0, 16'h0200);
    run_frame(12, 16'h8000, 16'h0ABC, 1'b0, 1'b1, 16'h0ABC);

    // bad marker and over-long frame
    run_frame(12, 16'h0000, 16'h1111, 1'b0, 1'b0, 16'h0ABC);
    run_frame(13, 16'h8000, 16'h2222, 1'b0, 1'b0, 16'h0ABC);

    // error counter saturation
    for (int k = 0; k < 260; k++) quick_bad_frame();
    check("ec_saturate", {24'b0, error_count}, 32'd255);
    check("fc_after_bad", {16'b0, frame_count}, 32'd6);
    check("pwm_after_bad", {16'b0, pwm_ref}, 32'h0ABC);
    exp_ec = 8'hFF;

    // reset mid-frame with ss_n held low
    ss_n = 1'b0;
    step();
    check("mid_wren_on", {31'b0, wren}, 32'd1);
    write_ack = 1'b1;
    step();
    write_ack = 1'b0;
    reset = 1'b1;
    step();
    check("mid_rst_wren", {31'b0, wren}, 32'd0);
    check("mid_rst_counts", {8'b0, frame_count, error_count}, 32'd0);
    check("mid_rst_pwm", {16'b0, pwm_ref}, 32'd0);
    reset = 1'b0;
    exp_fc = 16'd0; exp_ec = 8'd0;
    repeat (3) step();
    check("no_start_wren", {31'b0, wren}, 32'd0);
    check("no_start_state", {30'b0, dbg_state}, 32'd0);
    check("no_start_pulse", {29'b0, frame_done, pwm_valid, frame_error}, 32'd0);
    ss_n = 1'b1;
    step();
    ss_n = 1'b0;
    step();
    check("restart_wren", {31'b0, wren}, 32'd1);
    check("restart_tx", {16'b0, tx_word}, 32'd0);
    ss_n = 1'b1;
    step();
    check("abort_error", {31'b0, frame_error}, 32'd1);
    check("abort_ec", {24'b0, error_count}, 32'd1);
    exp_ec = 8'd1;
    step();
    run_frame(12, 16'h8000, 16'h0042, 1'b0, 1'b1, 16'h0042);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
